sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-client arbiter and sequencer for the dual-port synchronous SRAM (`DUALPORT_SRAM_SYN`). It accepts independent read/write requests from two clients and grants the SRAM write port and read port each by round-robin, so one read and one write can issue in the same cycle. It drives the SRAM's `i_cs`, `i_address_r`, `i_address_w`, `i_rd_en`, `i_wr_en` and `i_write_data`, and returns read data to the owning client with a fixed latency. Read-during-write to the same address is forwarded.

## Interface
- ADDR_WIDTH, 4, SRAM address width
- DATA_WIDTH, 8, data word width
- RAM_WIDTH, 16, SRAM depth in words; must be ≤ 2^ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rsr_n  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- c0_req, c1_req  in  1  client request valid
- c0_we, c1_we  in  1  1 = write, 0 = read
- c0_addr, c1_addr  in  ADDR_WIDTH  request address
- c0_wdata, c1_wdata  in  DATA_WIDTH  write data
- c0_gnt, c1_gnt  out  1  request accepted this cycle (combinational)
- c0_rvalid, c1_rvalid  out  1  registered read-return strobe
- c0_rdata, c1_rdata  out  DATA_WIDTH  registered read data, held until the next return to that client
- sram_cs  out  1  drives SRAM i_cs
- sram_rd_en, sram_wr_en  out  1  drive i_rd_en, i_wr_en
- sram_addr_r, sram_addr_w  out  ADDR_WIDTH  drive i_address_r, i_address_w
- sram_wdata  out  DATA_WIDTH  drives i_write_data
- sram_rdata  in  DATA_WIDTH  from o_read_data; valid one cycle after sram_rd_en

## Operation
- A transfer occurs when cN_req and cN_gnt are both high in the same cycle. A client presents one request per cycle, either read or write.
- Write arbitration: the write candidates are the clients with req=1 and we=1.
  - If there is one candidate, it is granted.
  - If there are two, the client selected by the write pointer `wptr` is granted. `wptr` then toggles to the other client.
  - `wptr` changes only on a contended grant.
- Read arbitration: same rules, applied independently to candidates with we=0, using the read pointer `rptr`.
- Resulting cases:
  - c0 reading while c1 writes: both are granted in the same cycle.
  - Two readers or two writers: one is granted, and the loser is guaranteed a grant within 2 cycles.
- SRAM command is combinational from the grant:
  - sram_wr_en = a write was granted; sram_rd_en = a read was granted.
  - sram_cs = sram_wr_en | sram_rd_en.
  - Addresses and write data are taken from the granted client. When a port is idle, its address and data outputs are 0.
- Out-of-range handling (addr ≥ RAM_WIDTH): the request is still granted.
  - Write: sram_wr_en is suppressed.
  - Read: sram_rd_en is suppressed, and the return carries rdata = 0 with rvalid = 1.
- Forwarding: if a granted read and a granted write have the same in-range address in cycle T, the read returns that cycle's write data, not sram_rdata.
- Read pipeline:
  - Stage 1 (registered at end of T): owner id, valid flag, out-of-range flag, forward flag, forward data.
  - Stage 2 (registered at end of T+1): select 0, forward data, or sram_rdata; load cN_rdata; pulse cN_rvalid for the owner.
- Back-to-back reads are fully pipelined at one per cycle per port.

## Timing
- Grant: same cycle as the request, with no bubble.
- Write: the SRAM write commits at the clock edge ending cycle T.
- Read accepted in cycle T: cN_rvalid is high for exactly cycle T+2 with the data in cN_rdata. Latency is 2 cycles.
- Reset (rsr_n low, including mid-operation):
  - All gnt, sram_cs, sram_rd_en and sram_wr_en are forced to 0.
  - Pipeline valid flags and the rvalid outputs are cleared to 0; rdata outputs and the sram address/data outputs go to 0.
  - wptr and rptr reset to client 0.
  - Reads in flight are dropped with no return.
- First cycle after reset release: normal arbitration. If both clients contend on a port, client 0 wins.

## Test plan
- Single write then read: c0 writes 8'hA5 to addr 3 in cycle T; c0 reads addr 3 in cycle T+1 → c0_rvalid=1 in T+3, c0_rdata=8'hA5. Check sram_wr_en/sram_addr_w=3 in T.
- Concurrent ports: c0 reads addr 5 (holds 8'h11) while c1 writes 8'h22 to addr 6 in the same cycle → both gnt=1; c0_rdata=8'h11 two cycles later; a later read of addr 6 returns 8'h22.
- Round-robin: both clients write every cycle for 4 cycles starting after reset → grants alternate c0, c1, c0, c1; never both in one cycle.
- Forwarding: addr 7 holds 8'h00; in the same cycle c1 writes 8'h5A to addr 7 and c0 reads addr 7 → c0_rdata=8'h5A at T+2.
- Out of range: with RAM_WIDTH=12, c1 writes addr 13 and then reads addr 13 → both granted; sram_wr_en and sram_rd_en stay 0; c1_rvalid=1 with c1_rdata=0.
- Reset mid-read: c0 read is granted in T; rsr_n is pulled low in T+1 → c0_rvalid stays 0 and all outputs are 0; after release, contended reads grant c0 first.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundle of client request/return signals and SRAM command signals around sram_port_arbiter.
// The arbiter takes the slave view; clients plus the SRAM model take the master view.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  c0_req,    c1_req;
    logic                  c0_we,     c1_we;
    logic [ADDR_WIDTH-1:0] c0_addr,   c1_addr;
    logic [DATA_WIDTH-1:0] c0_wdata,  c1_wdata;
    logic                  c0_gnt,    c1_gnt;
    logic                  c0_rvalid, c1_rvalid;
    logic [DATA_WIDTH-1:0] c0_rdata,  c1_rdata;

    logic                  sram_cs;
    logic                  sram_rd_en;
    logic                  sram_wr_en;
    logic [ADDR_WIDTH-1:0] sram_addr_r;
    logic [ADDR_WIDTH-1:0] sram_addr_w;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  sram_rdata,
        output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        output sram_cs, sram_rd_en, sram_wr_en, sram_addr_r, sram_addr_w, sram_wdata
    );

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output sram_rdata,
        input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        input  sram_cs, sram_rd_en, sram_wr_en, sram_addr_r, sram_addr_w, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-client arbiter for a dual-port synchronous SRAM: independent round-robin grants on the
// read and write ports, same-address write-to-read forwarding, fixed two-cycle read return.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RAM_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rsr_n,
    sram_port_arbiter_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_WIDTH);

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } client_req_t;

    client_req_t [1:0] cl;

    assign cl[0] = '{req: bus.c0_req, we: bus.c0_we, addr: bus.c0_addr, wdata: bus.c0_wdata};
    assign cl[1] = '{req: bus.c1_req, we: bus.c1_we, addr: bus.c1_addr, wdata: bus.c1_wdata};

    // A lone candidate always wins; the pointer only breaks a tie between two.
    function automatic logic [1:0] arbitrate(input logic [1:0] cand, input logic ptr);
        logic [1:0] gnt;
        gnt = cand;
        if (cand == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
        return gnt;
    endfunction

    logic                  wptr, rptr;
    logic [1:0]            w_cand, r_cand;
    logic [1:0]            w_gnt, r_gnt;
    logic                  w_any, r_any;
    logic                  w_sel, r_sel;
    logic                  w_oor, r_oor;
    logic                  fwd;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [DATA_WIDTH-1:0] w_data;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_cand = '0;
        r_cand = '0;
        for (int i = 0; i < 2; i++) begin
            w_cand[i] = cl[i].req &  cl[i].we;
            r_cand[i] = cl[i].req & ~cl[i].we;
        end

        // Holding rsr_n low silences every grant and SRAM command immediately.
        w_gnt = rsr_n ? arbitrate(w_cand, wptr) : 2'b00;
        r_gnt = rsr_n ? arbitrate(r_cand, rptr) : 2'b00;

        w_any = |w_gnt;
        r_any = |r_gnt;
        w_sel = w_gnt[1];
        r_sel = r_gnt[1];

        w_addr = w_any ? cl[w_sel].addr  : '0;
        w_data = w_any ? cl[w_sel].wdata : '0;
        r_addr = r_any ? cl[r_sel].addr  : '0;

        w_oor = w_any & ({1'b0, w_addr} >= RAM_LIMIT);
        r_oor = r_any & ({1'b0, r_addr} >= RAM_LIMIT);

        // An in-range read address equal to the write address implies the write is in range too.
        fwd = r_any & w_any & ~r_oor & (r_addr == w_addr);
    end

    assign bus.c0_gnt      = w_gnt[0] | r_gnt[0];
    assign bus.c1_gnt      = w_gnt[1] | r_gnt[1];
    assign bus.sram_wr_en  = w_any & ~w_oor;
    assign bus.sram_rd_en  = r_any & ~r_oor;
    assign bus.sram_cs     = (w_any & ~w_oor) | (r_any & ~r_oor);
    assign bus.sram_addr_w = w_addr;
    assign bus.sram_wdata  = w_data;
    assign bus.sram_addr_r = r_addr;

    logic                  s1_valid;
    logic                  s1_owner;
    logic                  s1_oor;
    logic                  s1_fwd;
    logic [DATA_WIDTH-1:0] s1_fdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rsr_n) begin
        if (!rsr_n) begin
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            s1_valid <= 1'b0;
            s1_owner <= 1'b0;
            s1_oor   <= 1'b0;
            s1_fwd   <= 1'b0;
            s1_fdata <= '0;
        end else begin
            if (w_cand == 2'b11) wptr <= ~wptr;
            if (r_cand == 2'b11) rptr <= ~rptr;
            s1_valid <= r_any;
            s1_owner <= r_sel;
            s1_oor   <= r_oor;
            s1_fwd   <= fwd;
            s1_fdata <= w_data;
        end
    end

    logic [DATA_WIDTH-1:0]       ret_data;
    logic [1:0]                  rvalid_q;
    logic [1:0][DATA_WIDTH-1:0]  rdata_q;

    always_comb begin
        ret_data = bus.sram_rdata;
        if (s1_oor)      ret_data = '0;
        else if (s1_fwd) ret_data = s1_fdata;
    end

    // rdata is only reloaded on a return to its owner, so it holds between returns.
    always_ff @(posedge clk or negedge rsr_n) begin
        if (!rsr_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            if (s1_valid) begin
                rvalid_q[s1_owner] <= 1'b1;
                rdata_q[s1_owner]  <= ret_data;
            end
        end
    end

    assign bus.c0_rvalid = rvalid_q[0];
    assign bus.c1_rvalid = rvalid_q[1];
    assign bus.c0_rdata  = rdata_q[0];
    assign bus.c1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter with a behavioural SRAM and a
// cycle-level reference model built from the arbitration, forwarding and return rules.
module tb_sram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RW = 12;

    logic clk   = 1'b0;
    logic rsr_n = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_WIDTH  (RW)
    ) dut (
        .clk   (clk),
        .rsr_n (rsr_n),
        .bus   (bus)
    );

    // Behavioural dual-port SRAM: read data appears one cycle after rd_en, old data on collision.
    logic [DW-1:0] sram_mem [16] = '{default: '0};
    logic [DW-1:0] sram_q = '0;

    always @(posedge clk) begin
        if (bus.sram_wr_en) sram_mem[bus.sram_addr_w] <= bus.sram_wdata;
        if (bus.sram_rd_en) sram_q <= sram_mem[bus.sram_addr_r];
    end

    assign bus.sram_rdata = sram_q;

    // Reference model state.
    typedef struct {
        int          due;
        bit          cl;
        logic [DW-1:0] data;
    } ret_t;

    logic [DW-1:0] ref_mem [16] = '{default: '0};
    ret_t          pend [$];
    bit            m_wptr = 1'b0;
    bit            m_rptr = 1'b0;
    logic [DW-1:0] held0 = '0;
    logic [DW-1:0] held1 = '0;
    int            cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    endtask

    function automatic logic [1:0] pick(input logic [1:0] cand, input bit ptr);
        if (cand == 2'b11) return ptr ? 2'b10 : 2'b01;
        return cand;
    endfunction

    // One clock cycle: called at posedge+1, drives inputs, checks at the falling edge, advances model.
    task automatic step(input logic q0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic q1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic [1:0]    wc, rc, wg, rg;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, rdat;
        bit            w_in, r_in, e_rv0, e_rv1;

        bus.c0_req = q0; bus.c0_we = we0; bus.c0_addr = a0; bus.c0_wdata = d0;
        bus.c1_req = q1; bus.c1_we = we1; bus.c1_addr = a1; bus.c1_wdata = d1;

        wc = {q1 & we1, q0 & we0};
        rc = {q1 & ~we1, q0 & ~we0};
        wg = pick(wc, m_wptr);
        rg = pick(rc, m_rptr);
        wa = wg[1] ? a1 : (wg[0] ? a0 : '0);
        wd = wg[1] ? d1 : (wg[0] ? d0 : '0);
        ra = rg[1] ? a1 : (rg[0] ? a0 : '0);
        w_in = (wg != 0) && (int'(wa) < RW);
        r_in = (rg != 0) && (int'(ra) < RW);

        if (!r_in)                   rdat = '0;
        else if (w_in && (wa == ra)) rdat = wd;
        else                         rdat = ref_mem[ra];

        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].cl) begin e_rv1 = 1'b1; held1 = pend[0].data; end
            else            begin e_rv0 = 1'b1; held0 = pend[0].data; end
            void'(pend.pop_front());
        end

        #4;
        check("c0_gnt",      32'(bus.c0_gnt),      32'(wg[0] | rg[0]));
        check("c1_gnt",      32'(bus.c1_gnt),      32'(wg[1] | rg[1]));
        check("sram_wr_en",  32'(bus.sram_wr_en),  32'(w_in));
        check("sram_rd_en",  32'(bus.sram_rd_en),  32'(r_in));
        check("sram_cs",     32'(bus.sram_cs),     32'(w_in | r_in));
        check("sram_addr_w", 32'(bus.sram_addr_w), 32'(wa));
        check("sram_wdata",  32'(bus.sram_wdata),  32'(wd));
        check("sram_addr_r", 32'(bus.sram_addr_r), 32'(ra));
        check("c0_rvalid",   32'(bus.c0_rvalid),   32'(e_rv0));
        check("c1_rvalid",   32'(bus.c1_rvalid),   32'(e_rv1));
        check("c0_rdata",    32'(bus.c0_rdata),    32'(held0));
        check("c1_rdata",    32'(bus.c1_rdata),    32'(held1));

        if (w_in) ref_mem[wa] = wd;
        if (wc == 2'b11) m_wptr = ~m_wptr;
        if (rc == 2'b11) m_rptr = ~m_rptr;
        if (rg != 0) pend.push_back('{due: cyc + 2, cl: rg[1], data: rdat});
        cyc++;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic rand_step();
        step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    // Holds rsr_n low for n cycles with random requests present; everything must read as zero.
    task automatic reset_cycles(input int n);
        rsr_n = 1'b0;
        pend.delete();
        held0  = '0;
        held1  = '0;
        m_wptr = 1'b0;
        m_rptr = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.c0_req = 1'b1; bus.c0_we = 1'($urandom); bus.c0_addr = AW'($urandom); bus.c0_wdata = DW'($urandom);
            bus.c1_req = 1'b1; bus.c1_we = 1'($urandom); bus.c1_addr = AW'($urandom); bus.c1_wdata = DW'($urandom);
            #4;
            check("rst_c0_gnt",      32'(bus.c0_gnt),      32'd0);
            check("rst_c1_gnt",      32'(bus.c1_gnt),      32'd0);
            check("rst_sram_cs",     32'(bus.sram_cs),     32'd0);
            check("rst_sram_rd_en",  32'(bus.sram_rd_en),  32'd0);
            check("rst_sram_wr_en",  32'(bus.sram_wr_en),  32'd0);
            check("rst_sram_addr_r", 32'(bus.sram_addr_r), 32'd0);
            check("rst_sram_addr_w", 32'(bus.sram_addr_w), 32'd0);
            check("rst_sram_wdata",  32'(bus.sram_wdata),  32'd0);
            check("rst_c0_rvalid",   32'(bus.c0_rvalid),   32'd0);
            check("rst_c1_rvalid",   32'(bus.c1_rvalid),   32'd0);
            check("rst_c0_rdata",    32'(bus.c0_rdata),    32'd0);
            check("rst_c1_rdata",    32'(bus.c1_rdata),    32'd0);
            cyc++;
            @(posedge clk);
            #1;
        end
        rsr_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.c0_req = 0; bus.c0_we = 0; bus.c0_addr = '0; bus.c0_wdata = '0;
        bus.c1_req = 0; bus.c1_we = 0; bus.c1_addr = '0; bus.c1_wdata = '0;
        @(posedge clk);
        #1;
        reset_cycles(2);

        // Contended writes straight out of reset: c0, c1, c0, c1.
        for (int i = 0; i < 4; i++) step(1, 1, AW'(i), DW'(8'h30 + i), 1, 1, AW'(i + 4), DW'(8'h40 + i));

        // Single write then read-back of addr 3.
        step(1, 1, 4'd3, 8'hA5, 0, 0, '0, '0);
        step(1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
        idle(2);

        // Concurrent read (addr 5) and write (addr 6), then read addr 6 back.
        step(0, 0, '0, '0, 1, 1, 4'd5, 8'h11);
        step(1, 0, 4'd5, 8'h00, 1, 1, 4'd6, 8'h22);
        idle(2);
        step(0, 0, '0, '0, 1, 0, 4'd6, 8'h00);
        idle(2);

        // Same-cycle write and read of addr 7 forwards the new data.
        step(1, 1, 4'd7, 8'h00, 0, 0, '0, '0);
        step(1, 0, 4'd7, 8'h00, 1, 1, 4'd7, 8'h5A);
        idle(2);

        // Out-of-range write and read of addr 13.
        step(0, 0, '0, '0, 1, 1, 4'd13, 8'h77);
        step(0, 0, '0, '0, 1, 0, 4'd13, 8'h00);
        idle(2);

        for (int i = 0; i < 400; i++) rand_step();
        idle(2);

        // Reset one cycle after a granted read: that read never returns.
        step(1, 0, 4'd2, 8'h00, 0, 0, '0, '0);
        reset_cycles(2);
        step(1, 0, 4'd4, 8'h00, 1, 0, 4'd9, 8'h00);
        step(1, 0, 4'd4, 8'h00, 1, 0, 4'd9, 8'h00);
        idle(3);

        for (int i = 0; i < 100; i++) rand_step();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
